// File: rtl/signal_control_unit.sv
// Trigger-driven signal override unit: a config-programmable one/two-stage trigger FSM
// that forces masked bits of a control bus for HOLD cycles. Optional macro: SCU_EVENT_CNT_EN.
module signal_control_unit #(
  parameter int OBS_W  = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OBS_W-1:0]  observe_port,
  input  logic [CTRL_W-1:0] control_port_in,
  output logic [CTRL_W-1:0] control_port_out,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [1:0]        state,
`ifdef SCU_EVENT_CNT_EN
  output logic [15:0]       event_count,
`endif
  output logic              fire
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT0  = 2'd1,
    S_WAIT1  = 2'd2,
    S_ACTIVE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              fire_q, fire_d;
  logic              arm_q, two_stage_q;
  logic [OBS_W-1:0]  t0_mask_q, t0_val_q, t1_mask_q, t1_val_q;
  logic [15:0]       window_q, hold_q;
  logic [CTRL_W-1:0] ovr_mask_q, ovr_val_q;
  logic              t0_hit, t1_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q       <= 1'b0;
      two_stage_q <= 1'b0;
      t0_mask_q   <= '0;
      t0_val_q    <= '0;
      t1_mask_q   <= '0;
      t1_val_q    <= '0;
      window_q    <= '0;
      hold_q      <= '0;
      ovr_mask_q  <= '0;
      ovr_val_q   <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        4'd0: begin
          arm_q       <= cfg_wdata[0];
          two_stage_q <= cfg_wdata[1];
        end
        4'd1: t0_mask_q  <= OBS_W'(cfg_wdata);
        4'd2: t0_val_q   <= OBS_W'(cfg_wdata);
        4'd3: t1_mask_q  <= OBS_W'(cfg_wdata);
        4'd4: t1_val_q   <= OBS_W'(cfg_wdata);
        4'd5: window_q   <= cfg_wdata;
        4'd6: hold_q     <= cfg_wdata;
        4'd7: ovr_mask_q <= CTRL_W'(cfg_wdata);
        4'd8: ovr_val_q  <= CTRL_W'(cfg_wdata);
        default: ;
      endcase
    end
  end

  assign t0_hit = (t0_mask_q != '0) && ((observe_port & t0_mask_q) == (t0_val_q & t0_mask_q));
  assign t1_hit = (t1_mask_q != '0) && ((observe_port & t1_mask_q) == (t1_val_q & t1_mask_q));

  // In ACTIVE, cnt==0 can only come from HOLD==0 at entry (the countdown leaves at 1),
  // so it doubles as the "hold until disarm" marker.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!arm_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT0;
        S_WAIT0: begin
          if (t0_hit) begin
            if (two_stage_q) begin
              state_d = S_WAIT1;
              cnt_d   = window_q;
            end else begin
              state_d = S_ACTIVE;
              cnt_d   = hold_q;
            end
          end
        end
        S_WAIT1: begin
          if (t1_hit) begin
            state_d = S_ACTIVE;
            cnt_d   = hold_q;
          end else if (cnt_q == '0) begin
            state_d = S_WAIT0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_ACTIVE: begin
          if (cnt_q == 16'd1) begin
            state_d = S_WAIT0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    fire_d = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
    end
  end

`ifdef SCU_EVENT_CNT_EN
  logic [15:0] evt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else if (cfg_we && (cfg_addr == 4'd9)) begin
      evt_q <= '0;
    end else if (fire_d && (evt_q != '1)) begin
      evt_q <= evt_q + 16'd1;
    end
  end

  assign event_count = evt_q;
`endif

  assign state            = state_q;
  assign fire             = fire_q;
  assign control_port_out = (state_q == S_ACTIVE)
                          ? ((control_port_in & ~ovr_mask_q) | (ovr_val_q & ovr_mask_q))
                          : control_port_in;

endmodule

// File: tb/tb_signal_control_unit.sv
// Scoreboard bench for signal_control_unit: stimulus queues expected outputs,
// a monitor pops and compares them after each clock edge or reset assertion.
module tb_signal_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  observe_port = '0;
  logic [7:0]  control_port_in = 8'hFF;
  logic [7:0]  control_port_out;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [1:0]  state;
  logic        fire;
`ifdef SCU_EVENT_CNT_EN
  logic [15:0] event_count;
`endif

  signal_control_unit #(.OBS_W(5), .CTRL_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .observe_port     (observe_port),
    .control_port_in  (control_port_in),
    .control_port_out (control_port_out),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .state            (state),
`ifdef SCU_EVENT_CNT_EN
    .event_count      (event_count),
`endif
    .fire             (fire)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic [7:0] out;
    logic       fire;
    int         ec;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (state !== e.st || control_port_out !== e.out || fire !== e.fire) begin
          miscompares++;
          $display("FAIL %s: got state=%0d out=%h fire=%b, required state=%0d out=%h fire=%b",
                   e.name, state, control_port_out, fire, e.st, e.out, e.fire);
        end
`ifdef SCU_EVENT_CNT_EN
        if (e.ec >= 0 && event_count !== 16'(e.ec)) begin
          miscompares++;
          $display("FAIL %s_evt: got event_count=%0d, required %0d", e.name, event_count, e.ec);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [1:0] st, input logic [7:0] o,
                     input logic f, input int ec = -1);
    exp_t e;
    e.name = n; e.st = st; e.out = o; e.fire = f; e.ec = ec;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] obs, input logic [7:0] cpi);
    @(negedge clk);
    cfg_we = 1'b0;
    observe_port = obs;
    control_port_in = cpi;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
  endtask

  initial begin : stimulus
    // Reset state
    @(negedge clk);
    chk("reset_state", 2'd0, 8'hFF, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-stage trigger, HOLD=3
    wr(4'd1, 16'h0001);
    wr(4'd2, 16'h0001);
    wr(4'd7, 16'h0002);
    wr(4'd8, 16'h0000);
    wr(4'd6, 16'd3);
    wr(4'd0, 16'h0001);
    drive(5'h00, 8'hFF); chk("ss_arm", 2'd1, 8'hFF, 1'b0);
    drive(5'h01, 8'hFF); chk("ss_fire", 2'd3, 8'hFD, 1'b1);
    drive(5'h00, 8'hFF); chk("ss_hold2", 2'd3, 8'hFD, 1'b0);
    drive(5'h00, 8'hFF); chk("ss_hold3", 2'd3, 8'hFD, 1'b0);
    drive(5'h00, 8'hFF); chk("ss_expire", 2'd1, 8'hFF, 1'b0);
    drive(5'h00, 8'hFF); chk("ss_idle_w0", 2'd1, 8'hFF, 1'b0);

    // Two-stage, WINDOW=2, T1 never hits
    wr(4'd3, 16'h0002);
    wr(4'd4, 16'h0002);
    wr(4'd5, 16'd2);
    wr(4'd0, 16'h0003);
    drive(5'h00, 8'hFF); chk("ts_wait0", 2'd1, 8'hFF, 1'b0);
    drive(5'h01, 8'hFF); chk("ts_w1_a", 2'd2, 8'hFF, 1'b0);
    drive(5'h00, 8'hFF); chk("ts_w1_b", 2'd2, 8'hFF, 1'b0);
    drive(5'h00, 8'hFF); chk("ts_w1_c", 2'd2, 8'hFF, 1'b0);
    drive(5'h00, 8'hFF); chk("ts_timeout", 2'd1, 8'hFF, 1'b0);
    drive(5'h00, 8'hFF); chk("ts_stay", 2'd1, 8'hFF, 1'b0);

    // WINDOW=0, T1 coincident with expiry: match wins
    wr(4'd5, 16'd0);
    drive(5'h00, 8'hFF); chk("w0_wait0", 2'd1, 8'hFF, 1'b0);
    drive(5'h01, 8'hFF); chk("w0_wait1", 2'd2, 8'hFF, 1'b0);
    drive(5'h02, 8'hFF); chk("w0_match", 2'd3, 8'hFD, 1'b1);
    drive(5'h00, 8'hFF); chk("w0_hold2", 2'd3, 8'hFD, 1'b0);
    drive(5'h00, 8'hFF); chk("w0_hold3", 2'd3, 8'hFD, 1'b0);
    drive(5'h00, 8'hFF); chk("w0_expire", 2'd1, 8'hFF, 1'b0);

    // HOLD=0: override until disarm; live override writes and passthrough
    wr(4'd0, 16'h0001);
    wr(4'd6, 16'd0);
    wr(4'd7, 16'h000F);
    wr(4'd8, 16'h0005);
    drive(5'h00, 8'hA0); chk("inf_wait0", 2'd1, 8'hA0, 1'b0);
    drive(5'h01, 8'hA0); chk("inf_fire", 2'd3, 8'hA5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(5'h00, 8'hA0); chk("inf_hold", 2'd3, 8'hA5, 1'b0);
    end
    wr(4'd8, 16'h000A); chk("inf_ovr_wr", 2'd3, 8'hAA, 1'b0);
    drive(5'h00, 8'h30); chk("inf_cpi", 2'd3, 8'h3A, 1'b0);
    wr(4'd0, 16'h0000); chk("inf_disarm_edge", 2'd3, 8'h3A, 1'b0);
    drive(5'h00, 8'h30); chk("inf_idle", 2'd0, 8'h30, 1'b0);

    // Reset asserted mid-ACTIVE
    wr(4'd0, 16'h0001);
    drive(5'h00, 8'h30); chk("rst_pre_w0", 2'd1, 8'h30, 1'b0);
    drive(5'h01, 8'h30); chk("rst_pre_fire", 2'd3, 8'h3A, 1'b1, 4);
    drive(5'h00, 8'h30); chk("rst_pre_act", 2'd3, 8'h3A, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_async", 2'd0, 8'h30, 1'b0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_hold", 2'd0, 8'h30, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cleared T0_MASK never matches, whatever the value and observe pattern
    wr(4'd2, 16'h001F);
    wr(4'd0, 16'h0001);
    drive(5'h00, 8'h30); chk("m0_wait0", 2'd1, 8'h30, 1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 8'h30); chk("m0_nomatch", 2'd1, 8'h30, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL sb_drain: got %0d unchecked entries, required 0", sb.size());
      vectors += sb.size();
      miscompares += sb.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/signal_control_unit.md
SIGNAL_CONTROL_UNIT -- requirements
Module: signal_control_unit

Interface
REQ-001 SHALL have parameter OBS_W, default 5, width of the observe bus from the patched design.
REQ-002 SHALL have parameter CTRL_W, default 8, width of the control loop buses.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port observe_port, input, OBS_W, observed signals from the patched design.
REQ-006 SHALL have port control_port_in, input, CTRL_W, original (pre-control) signal values from the patched design.
REQ-007 SHALL have port control_port_out, output, CTRL_W, values driven back into the patched design.
REQ-008 SHALL have ports cfg_we (input, 1), cfg_addr (input, 4) and cfg_wdata (input, 16), forming the configuration write port.
REQ-009 SHALL have port state, output, 2, current FSM state: 0 IDLE, 1 WAIT0, 2 WAIT1, 3 ACTIVE.
REQ-010 SHALL have port fire, output, 1, a one-cycle pulse on entry to ACTIVE.

Function
REQ-011 SHALL write cfg_wdata, truncated to the register width, into the addressed register on a clk edge with cfg_we=1.
- Map: 0 CTRL (bit0 arm, bit1 two_stage); 1 T0_MASK; 2 T0_VAL; 3 T1_MASK; 4 T1_VAL; 5 WINDOW[15:0]; 6 HOLD[15:0]; 7 OVR_MASK; 8 OVR_VAL.
- Unmapped addresses are ignored.
REQ-012 SHALL evaluate trigger Tn as match = (T*_MASK!=0) && ((observe_port & T*_MASK) == (T*_VAL & T*_MASK)); an all-zero mask never matches.
REQ-013 SHALL drive control_port_out combinationally, with zero latency:
- state==ACTIVE: (control_port_in & ~OVR_MASK) | (OVR_VAL & OVR_MASK).
- otherwise: control_port_in unchanged.
REQ-014 SHALL go to IDLE at the next edge from any state when arm=0; arm=0 has priority over all other transitions.
REQ-015 SHALL go IDLE -> WAIT0 at the next edge when arm=1.
REQ-016 SHALL leave WAIT0 on a T0 match as follows:
- two_stage=1: go to WAIT1 and load cnt=WINDOW.
- two_stage=0: go to ACTIVE and load cnt=HOLD.
REQ-017 SHALL, in WAIT1:
- T1 match: go to ACTIVE and load cnt=HOLD.
- else cnt==0: return to WAIT0.
- else: decrement cnt.
- T1 match coincident with cnt==0 goes to ACTIVE (match wins).
REQ-018 SHALL, in ACTIVE:
- HOLD==0 at entry: remain until disarm.
- otherwise: return to WAIT0 when cnt==1, else decrement cnt.
- Result: the override lasts exactly HOLD cycles.
REQ-019 SHALL apply the override from the cycle after the edge that sampled the final trigger match (one-cycle trigger latency).
REQ-020 SHALL latch WINDOW/HOLD into cnt only at state entry; later writes to WINDOW/HOLD do not affect a running count.
REQ-021 SHALL make mask/value/override register writes effective in the cycle after the write edge, including while in ACTIVE.
REQ-022 SHALL rearm automatically: after ACTIVE expires, the next T0 match re-triggers without software action.

Reset
REQ-023 SHALL asynchronously clear all registers, cnt and the state (to IDLE) on rst_n=0; fire=0 and control_port_out=control_port_in during reset.
REQ-024 SHALL, on reset asserted mid-ACTIVE, drop the override immediately (asynchronously).

Configuration
REQ-025 SHALL, with macro SCU_EVENT_CNT_EN defined:
- add output event_count[15:0], incremented on each fire and saturating at 0xFFFF.
- clear event_count on reset or on any write to address 9.
REQ-026 SHALL, without SCU_EVENT_CNT_EN, omit the event_count port and logic; address 9 is then unmapped.

Verification
REQ-027 SHALL check single-stage: OBS_W=5, T0_MASK=0x01, T0_VAL=0x01, OVR_MASK=0x02, OVR_VAL=0x00, HOLD=3, arm; observe=0x01 for 1 cycle, control_port_in=0xFF -> fire once, control_port_out=0xFD for exactly 3 cycles, then 0xFF, state=WAIT0.
REQ-028 SHALL check two-stage timeout: two_stage=1, WINDOW=2, T0 hit, T1 never hits -> WAIT1 for 3 cycles, return to WAIT0, no fire.
REQ-029 SHALL check the boundary: two_stage=1, WINDOW=0, T1 matches the cycle after T0 -> ACTIVE (match wins over expiry).
REQ-030 SHALL check indefinite hold: HOLD=0, trigger, then write CTRL=0 after 10 cycles -> override held 10+ cycles and cleared the cycle after the disarm edge, state=IDLE.
REQ-031 SHALL check reset mid-ACTIVE: rst_n=0 -> control_port_out equals control_port_in immediately, state=0, all registers 0; with SCU_EVENT_CNT_EN, event_count=0.
REQ-032 SHALL check mask zero: T0_MASK=0 with any observe_port pattern -> never leaves WAIT0.
